// File: rtl/column_l1_deroute_if.sv
// Handshake bundle for the column-wise L1 de-route block: one stride group
// in per transfer, one realigned frame out per transfer, plus sticky errors.
interface column_l1_deroute_if #(
    parameter int QUAN_SIZE             = 4,
    parameter int STRIDE_UNIT_SIZE      = 51,
    parameter int STRIDE_WIDTH          = 5,
    parameter int BITWIDTH_SHIFT_FACTOR = $clog2(STRIDE_UNIT_SIZE - 1),
    parameter int STRIDE_IDX_WIDTH      = $clog2(STRIDE_WIDTH)
);
    logic                                             in_valid_i;
    logic                                             in_ready_o;
    logic [STRIDE_IDX_WIDTH-1:0]                      in_stride_idx_i;
    logic [BITWIDTH_SHIFT_FACTOR-1:0]                 in_shift_factor_i;
    logic [QUAN_SIZE*STRIDE_UNIT_SIZE-1:0]            in_msg_i;
    logic                                             out_valid_o;
    logic                                             out_ready_i;
    logic [STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE-1:0] out_msg_o;
    logic [2:0]                                       err_o;

    // Upstream route stage / downstream memory side (drives inputs of the block)
    modport master (
        output in_valid_i, in_stride_idx_i, in_shift_factor_i, in_msg_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_msg_o, err_o
    );

    // The de-route block itself
    modport slave (
        input  in_valid_i, in_stride_idx_i, in_shift_factor_i, in_msg_i, out_ready_i,
        output in_ready_o, out_valid_o, out_msg_o, err_o
    );
endinterface

// File: rtl/column_l1_deroute.sv
// Receive side of the column-wise 1st-level message route. Each accepted
// stride group is un-rotated by its shift factor (out[(i+f) mod Z] = in[i])
// through a two-register pipeline and dropped into its frame-buffer slot.
// When every slot has been written the whole frame is offered downstream.
module column_l1_deroute #(
    parameter int QUAN_SIZE             = 4,
    parameter int STRIDE_UNIT_SIZE      = 51,
    parameter int STRIDE_WIDTH          = 5,
    parameter int BITWIDTH_SHIFT_FACTOR = $clog2(STRIDE_UNIT_SIZE - 1),
    parameter int STRIDE_IDX_WIDTH      = $clog2(STRIDE_WIDTH)
) (
    input  logic               sys_clk,
    input  logic               rstn,
    column_l1_deroute_if.slave bus
);
    localparam int Z   = STRIDE_UNIT_SIZE;
    localparam int W   = STRIDE_WIDTH;
    localparam int Q   = QUAN_SIZE;
    localparam int BSF = BITWIDTH_SHIFT_FACTOR;
    localparam int SIW = STRIDE_IDX_WIDTH;
    localparam int GW  = Q * Z;
    localparam int FW  = W * GW;

    // Issued: set when a group is accepted; gates in_ready so frames never overlap.
    // Written: set when the rotated group lands in the buffer; all ones = frame ready.
    logic [W-1:0]   issued_q, issued_d;
    logic [W-1:0]   written_q, written_d;
    logic [2:0]     err_q, err_d;

    logic           s1_valid_q, s1_valid_d;
    logic [GW-1:0]  s1_msg_q;
    logic [SIW-1:0] s1_idx_q;
    logic [BSF-1:0] s1_shift_q, eff_shift_s;

    logic           s2_valid_q;
    logic [GW-1:0]  s2_msg_q, s2_msg_d;
    logic [SIW-1:0] s2_idx_q;

    logic [FW-1:0]  buf_q, buf_d;

    logic           accept_s, idx_ok_s, shift_ok_s, out_hs_s, dup_s;
    logic [W-1:0]   idx_onehot_s, wr_onehot_s;

    // Inverse circular shift of every bit-plane: out[(i+f) mod Z] = in[i],
    // i.e. out[j] = in[(j-f) mod Z]. f is already limited to 0..Z-1.
    function automatic logic [GW-1:0] rot_group(input logic [GW-1:0] v,
                                                input logic [BSF-1:0] f);
        logic [GW-1:0] r;
        int            src;
        r = '0;
        for (int b = 0; b < Q; b++) begin
            for (int j = 0; j < Z; j++) begin
                src = j - int'(f);
                if (src < 0) begin
                    src = src + Z;
                end else begin
                    src = src;
                end
                r[b*Z + j] = v[b*Z + src];
            end
        end
        return r;
    endfunction

    assign bus.in_ready_o  = ~(&issued_q);
    assign bus.out_valid_o = &written_q;
    assign bus.out_msg_o   = buf_q;
    assign bus.err_o       = err_q;

    // Handshake decode, factor sanitising, bitmap/error next-state and rotation
    always_comb begin
        accept_s     = bus.in_valid_i & ~(&issued_q);
        out_hs_s     = (&written_q) & bus.out_ready_i;
        idx_ok_s     = int'(bus.in_stride_idx_i) < W;
        shift_ok_s   = int'(bus.in_shift_factor_i) < Z;
        idx_onehot_s = {{(W-1){1'b0}}, 1'b1} << bus.in_stride_idx_i;
        wr_onehot_s  = {{(W-1){1'b0}}, 1'b1} << s2_idx_q;
        dup_s        = |(issued_q & idx_onehot_s);
        eff_shift_s  = shift_ok_s ? bus.in_shift_factor_i : {BSF{1'b0}};
        s1_valid_d   = accept_s & idx_ok_s;
        s2_msg_d     = rot_group(s1_msg_q, s1_shift_q);

        issued_d  = out_hs_s ? {W{1'b0}} : issued_q;
        written_d = out_hs_s ? {W{1'b0}} : written_q;
        if (accept_s && idx_ok_s) begin
            issued_d = issued_d | idx_onehot_s;
        end else begin
            issued_d = issued_d;
        end
        if (s2_valid_q) begin
            written_d = written_d | wr_onehot_s;
        end else begin
            written_d = written_d;
        end

        err_d    = err_q;
        err_d[0] = err_q[0] | (accept_s & ~idx_ok_s);
        err_d[1] = err_q[1] | (accept_s & idx_ok_s & dup_s);
        err_d[2] = err_q[2] | (accept_s & ~shift_ok_s);

        buf_d = buf_q;
        for (int s = 0; s < W; s++) begin
            if (s2_valid_q && (s2_idx_q == SIW'(s))) begin
                buf_d[s*GW +: GW] = s2_msg_q;
            end else begin
                buf_d[s*GW +: GW] = buf_q[s*GW +: GW];
            end
        end
    end

    // Pipeline stages, bitmaps, sticky errors and frame buffer
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            issued_q   <= {W{1'b0}};
            written_q  <= {W{1'b0}};
            err_q      <= 3'b000;
            s1_valid_q <= 1'b0;
            s1_msg_q   <= {GW{1'b0}};
            s1_idx_q   <= {SIW{1'b0}};
            s1_shift_q <= {BSF{1'b0}};
            s2_valid_q <= 1'b0;
            s2_msg_q   <= {GW{1'b0}};
            s2_idx_q   <= {SIW{1'b0}};
            buf_q      <= {FW{1'b0}};
        end else begin
            issued_q   <= issued_d;
            written_q  <= written_d;
            err_q      <= err_d;
            s1_valid_q <= s1_valid_d;
            if (accept_s) begin
                s1_msg_q   <= bus.in_msg_i;
                s1_idx_q   <= bus.in_stride_idx_i;
                s1_shift_q <= eff_shift_s;
            end else begin
                s1_msg_q   <= s1_msg_q;
                s1_idx_q   <= s1_idx_q;
                s1_shift_q <= s1_shift_q;
            end
            s2_valid_q <= s1_valid_q;
            s2_msg_q   <= s2_msg_d;
            s2_idx_q   <= s1_idx_q;
            buf_q      <= buf_d;
        end
    end
endmodule

// File: doc/column_l1_deroute.md
# column_l1_deroute

Receive side of the column-wise 1st-level message route. The block accepts one stride group of circularly shifted messages per cycle through a valid/ready handshake and applies the inverse circular shift for that group's shift factor. It collects all STRIDE_WIDTH groups of one base-matrix column into a frame buffer and presents the realigned frame downstream through a second valid/ready handshake. It sits between the L1 route output stage and the VNU-side message memory write port.

## Interface
- QUAN_SIZE, 4: message bits; one bit-plane per bit.
- STRIDE_UNIT_SIZE, 51: lanes per stride group (Z).
- STRIDE_WIDTH, 5: stride groups per frame (W).
- BITWIDTH_SHIFT_FACTOR, $clog2(STRIDE_UNIT_SIZE-1): shift-factor width.
- STRIDE_IDX_WIDTH, $clog2(STRIDE_WIDTH): stride index width.

Ports:
- sys_clk  in  1  single clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input group valid.
- in_ready_o  out  1  block can accept a group.
- in_stride_idx_i  in  STRIDE_IDX_WIDTH  destination stride group.
- in_shift_factor_i  in  BITWIDTH_SHIFT_FACTOR  forward shift factor f applied upstream.
- in_msg_i  in  QUAN_SIZE*STRIDE_UNIT_SIZE  bit-plane b at [b*Z +: Z].
- out_valid_o  out  1  realigned frame available.
- out_ready_i  in  1  downstream accepts the frame.
- out_msg_o  out  STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE  group s, plane b at [(s*QUAN_SIZE+b)*Z +: Z].
- err_o  out  3  sticky: [0] bad stride index, [1] duplicate stride, [2] shift factor ≥ Z.

## Operation
- Upstream forward shift: fwd[i] = orig[(i+f) mod Z]. This block computes out[(i+f) mod Z] = in[i] on every bit-plane, which restores orig.
- Accept: when in_valid_i && in_ready_o at a rising edge.
- Three-step pipeline:
  - S1 registers msg, idx and the effective factor.
  - S2 registers the rotated msg and idx.
  - The S2 result is written into frame-buffer slot idx, and written-bitmap bit idx is set.
- Effective factor: f if f < Z; otherwise 0, and err_o[2] is set.
- idx ≥ W: the group is accepted but dropped. No buffer write, no bitmap change, err_o[0] is set.
- Issued bitmap:
  - Set at accept time for a valid idx.
  - Accepting an idx whose issued bit is already set sets err_o[1]. That group still proceeds, and the later data overwrites the slot.
- Groups may arrive in any order.
- in_ready_o = !(issued bitmap all ones). This is a combinational decode of a register.
- Frame complete: written bitmap all ones, which drives out_valid_o = 1. out_msg_o is the buffer contents, held stable while out_valid_o && !out_ready_i.
- Output handshake at an edge clears both bitmaps. The buffer is not cleared (stale data is never exposed). out_valid_o falls and in_ready_o rises after that edge.
- err_o bits are sticky and cleared only by reset.
- Reset (including mid-frame): pipeline valids, both bitmaps, err_o and buffer go to 0, and in-flight groups are discarded.

## Timing
- Reset values:
  - in_ready_o = 1
  - out_valid_o = 0
  - out_msg_o = 0
  - err_o = 0
- Latency: last required group accepted at edge N → buffer written at edge N+2 → out_valid_o high from edge N+2.
- Throughput: one group per cycle. A full frame takes W accept cycles plus 2 cycles of drain.
- No overlap between frames: in_ready_o stays low from the edge that issues the last stride until the edge after the output handshake.
- If out_ready_i is already high when out_valid_o rises, the handshake completes at edge N+3, and in_ready_o is 1 after N+3.
- An error bit is visible the cycle after the offending accept edge.
- in_valid_i held while in_ready_o = 0 is not consumed. Upstream must keep its data stable until accepted.

## Test plan
1. **Reset:** assert rstn = 0 mid-cycle, asynchronously → immediately out_valid_o = 0, out_msg_o = 0, err_o = 0, in_ready_o = 1.
2. **Ordered frame:** strides 0..4 on consecutive cycles with f = 10·s; plane 0 has only lane 0 set, all other planes 0 → group s plane 0 has only lane 10·s set (0, 10, 20, 30, 40); out_valid_o rises 2 edges after the stride-4 accept.
3. **Wrap-around:** f = 50, plane 3 lane 3 set, all strides use the same data → output lane (3+50) mod 51 = 2 of plane 3 in every group; f = 0 → identity.
4. **Backpressure:** hold out_ready_i = 0 for 10 cycles after a frame completes → in_ready_o = 0, out_msg_o stable, next-frame group not accepted; raising out_ready_i completes the handshake, and the next group is accepted one edge later.
5. **Out-of-order and duplicate:** order 4, 2, 2(new data), 0, 1, 3 → err_o = 3'b010, slot 2 holds the second data, out_valid_o rises 2 edges after the stride-3 accept.
6. **Errors and mid-frame reset:**
   - idx = 6 → dropped, err_o[0] = 1.
   - f = 55 → treated as 0, err_o[2] = 1.
   - Reset after 3 accepts → out_valid_o stays 0; a subsequent clean frame matches scenario 2.
